// File: rtl/fifo_pkg.sv
// Shared types and sizing for the 16-entry single-clock FIFO.
// Pointers carry one extra wrap bit above the index.
package fifo_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 16;
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  typedef logic [DATA_WIDTH-1:0] data_ty;
  typedef logic [ADDR_WIDTH:0]   ptr_ty;
  typedef logic [ADDR_WIDTH-1:0] addr_ty;

  function automatic addr_ty ptr_idx(input ptr_ty p);
    return p[ADDR_WIDTH-1:0];
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// Register-array storage with one write port and one registered read port; 1-cycle read latency.
// No backpressure here: the caller gates wr_en/rd_en. Only the read register is reset.
module fifo_mem
  import fifo_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  data_ty mem_q [DEPTH];
  data_ty rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // A same-edge write to rd_addr (full with push+pop) still returns the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/sync_fifo_core.sv
// Single-clock 16-deep FIFO core: pointers, flags and error pulses; data_out lands 1 cycle after an accepted pop.
// Push while full is dropped unless a pop frees the slot; pop while empty is dropped. Both pulse an error flag.
module sync_fifo_core
  import fifo_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);
  ptr_ty wr_ptr_q, wr_ptr_d;
  ptr_ty rd_ptr_q, rd_ptr_d;
  logic  overflow_q, overflow_d;
  logic  underflow_q, underflow_d;
  logic  wr_en, rd_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (ptr_idx(wr_ptr_q) == ptr_idx(rd_ptr_q)) &&
                 (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
  assign count = wr_ptr_q - rd_ptr_q;

  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = push & full & ~pop;
    underflow_d = pop & empty;
    if (wr_en) wr_ptr_d = wr_ptr_q + ptr_ty'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + ptr_ty'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  fifo_mem u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (ptr_idx(wr_ptr_q)),
    .wr_data (data_in),
    .rd_en   (rd_en),
    .rd_addr (ptr_idx(rd_ptr_q)),
    .rd_data (data_out)
  );
endmodule

// File: tb/tb_sync_fifo_core.sv
// Directed stimulus with a queue-based reference; a negedge monitor checks each post-edge expectation.
module tb_sync_fifo_core;
  logic       clk;
  logic       rst;
  logic       push;
  logic [7:0] data_in;
  logic       pop;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  typedef struct {
    logic [7:0] dout;
    int         cnt;
    bit         full;
    bit         empty;
    bit         ovf;
    bit         unf;
  } exp_t;

  exp_t       exp_q [$];
  logic [7:0] model_q [$];
  logic [7:0] exp_dout;
  int         n_checks;
  int         n_err;

  sync_fifo_core dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .data_in   (data_in),
    .pop       (pop),
    .data_out  (data_out),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus; the reference state advances using pre-edge occupancy.
  task automatic cycle(input bit p, input logic [7:0] d, input bit q);
    exp_t e;
    bit fm, em, wr, rd;
    push    = p;
    data_in = d;
    pop     = q;
    fm = (model_q.size() == 16);
    em = (model_q.size() == 0);
    wr = p && (!fm || q);
    rd = q && !em;
    if (rd) exp_dout = model_q.pop_front();
    if (wr) model_q.push_back(d);
    e.dout  = exp_dout;
    e.cnt   = model_q.size();
    e.full  = (model_q.size() == 16);
    e.empty = (model_q.size() == 0);
    e.ovf   = p && fm && !q;
    e.unf   = q && em;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_empty"}, int'(empty), 1);
    chk({tag, "_full"}, int'(full), 0);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_dout"}, int'(data_out), 0);
    chk({tag, "_ovf"}, int'(overflow), 0);
    chk({tag, "_unf"}, int'(underflow), 0);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_state("async_rst");
    model_q.delete();
    exp_dout = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("data_out", int'(data_out), int'(e.dout));
        chk("count", int'(count), e.cnt);
        chk("full", int'(full), int'(e.full));
        chk("empty", int'(empty), int'(e.empty));
        chk("overflow", int'(overflow), int'(e.ovf));
        chk("underflow", int'(underflow), int'(e.unf));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    n_checks = 0;
    n_err    = 0;
    exp_dout = 8'h00;
    rst      = 1'b1;
    push     = 1'b0;
    pop      = 1'b0;
    data_in  = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("por");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Traffic then reset while the FIFO holds data.
    for (int i = 1; i <= 3; i++) cycle(1'b1, 8'(i), 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    mid_reset();

    // Fill 1..16.
    for (int i = 1; i <= 16; i++) cycle(1'b1, 8'(i), 1'b0);
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), 16);

    // Overflow attempts.
    for (int i = 0; i < 14; i++) cycle(1'b1, 8'hAA, 1'b0);
    chk("ovf_count", int'(count), 16);

    // Drain; expect 1..16 in order.
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("drain_last", int'(data_out), 16);
    chk("drain_empty", int'(empty), 1);

    // Underflow attempts.
    for (int i = 0; i < 40; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("unf_hold", int'(data_out), 16);
    chk("unf_flag", int'(underflow), 1);

    // Simultaneous push/pop with 5 stored.
    for (int i = 1; i <= 5; i++) cycle(1'b1, 8'(i), 1'b0);
    cycle(1'b1, 8'd6, 1'b1);
    chk("sim_mid_dout", int'(data_out), 1);
    chk("sim_mid_count", int'(count), 5);

    // Fill to full (holds 2..17) then push+pop at full.
    for (int i = 7; i <= 17; i++) cycle(1'b1, 8'(i), 1'b0);
    chk("sim_full_pre", int'(full), 1);
    cycle(1'b1, 8'd18, 1'b1);
    chk("sim_full_dout", int'(data_out), 2);
    chk("sim_full_count", int'(count), 16);

    // Drain 3..18, then push+pop at empty.
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("sim_drain_last", int'(data_out), 18);
    cycle(1'b1, 8'd7, 1'b1);
    chk("sim_empty_count", int'(count), 1);
    chk("sim_empty_unf", int'(underflow), 1);
    chk("sim_empty_dout", int'(data_out), 18);
    cycle(1'b0, 8'h00, 1'b1);
    chk("sim_empty_pop", int'(data_out), 7);

    // Wrap-around: occupancy stays within 1..15 across pointer rollover.
    for (int i = 0; i < 30; i++) cycle(1'b1, 8'(8'h40 + i), (i % 2) == 1);
    for (int i = 0; i < 15; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("wrap_last", int'(data_out), 8'h5D);

    repeat (3) @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
